// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives operands and start,
// the adder returns busy/done and the held result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus carry flop, WIDTH cycles per operation.
// Subtraction (invert B, preset carry) is built only when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sa, w_sa_nxt;
    logic [WIDTH-1:0] r_sb, w_sb_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_c, w_c_nxt;
    logic             r_cout, w_cout_nxt;

    logic             w_s;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_sb_load;
    logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sb_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load  = bus.sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.sub;
    assign w_sb_load    = bus.b;
    assign w_c_load     = 1'b0;
`endif

    assign w_s     = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_carry = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // A 1-bit result register has no upper slice to shift in from.
    generate
        if (WIDTH == 1) begin : g_sr_w1
            assign w_sr_shift = w_s;
        end else begin : g_sr_wn
            assign w_sr_shift = {w_s, r_sr[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_sr_nxt    = r_sr;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c;
        w_cout_nxt  = r_cout;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_sa_nxt    = bus.a;
                    w_sb_nxt    = w_sb_load;
                    w_c_nxt     = w_c_load;
                    w_sr_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StRun: begin
                w_c_nxt   = w_carry;
                w_sr_nxt  = w_sr_shift;
                w_sa_nxt  = r_sa >> 1;
                w_sb_nxt  = r_sb >> 1;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_sum_nxt   = w_sr_shift;
                    w_cout_nxt  = w_carry;
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sa    <= w_sa_nxt;
            r_sb    <= w_sb_nxt;
            r_sr    <= w_sr_nxt;
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_c     <= w_c_nxt;
            r_cout  <= w_cout_nxt;
        end
    end

    assign bus.busy = (r_state == StRun);
    assign bus.done = (r_state == StDone);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder, the sequential successor to the combinational half-adder cells. It accepts two WIDTH-bit operands on a start pulse and sums them one bit per clock through a single full-adder slice with a carry flop. It raises a one-cycle done pulse and holds the result until the next operation. It is the low-area arithmetic element for datapaths where throughput is not critical.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- sub  in  1  1 selects A−B; captured with the operands. Only honoured when SERIAL_ADDER_SUB_EN is defined.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when sum and cout become valid.
- sum  out  WIDTH  result register; held between operations.
- cout  out  1  carry out of the MSB. In subtract mode this is the no-borrow flag (1 when A ≥ B unsigned).

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing bits; busy=1.
  - DONE: done=1; behaves as IDLE for start acceptance.
- Accept (IDLE or DONE, start=1):
  - a goes to shift register SA.
  - b goes to SB, or ~b in subtract mode.
  - Carry flop c is loaded with sub in subtract mode, else 0.
  - Bit counter is cleared.
  - Next state is RUN.
- RUN, each edge:
  - s = SA[0]^SB[0]^c.
  - c ← majority(SA[0], SB[0], c).
  - Result shift register SR ← {s, SR[WIDTH-1:1]}.
  - SA and SB shift right by one.
  - Counter increments.
- Counter width is $clog2(WIDTH+1). On the edge that processes bit WIDTH−1:
  - sum ← final SR value.
  - cout ← final carry.
  - Next state is DONE.
- DONE lasts exactly one cycle. Next state is RUN if start=1, otherwise IDLE.
- sum and cout change only on a completing edge or reset. They never show partial results.
- start while in RUN is ignored; no queueing. Operand changes during RUN have no effect.
- All arithmetic is unsigned modulo 2^WIDTH. Signed overflow is not reported.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, c=0, counter=0. rst has priority over start.
- Let edge E0 be the edge where start is accepted:
  - busy=1 after E0 through edge E(WIDTH−1).
  - The last bit is processed on edge E(WIDTH).
  - done=1 and the result are visible after E(WIDTH).
- Latency from accepting edge to done: WIDTH cycles.
- Back-to-back operation: start=1 during the DONE cycle is accepted. busy rises on the next edge, giving one op per WIDTH+1 cycles.
- WIDTH=1: one RUN edge, then DONE, so done is 1 cycle after accept.
- Reset mid-RUN aborts the operation. No done pulse is produced and sum/cout clear to 0.
- start held high continuously starts a new op every WIDTH+1 cycles.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub is captured at accept.
  - sub=1 inverts B and presets the carry to 1, giving two's-complement subtraction.
  - cout is the no-borrow flag.
- SERIAL_ADDER_SUB_EN undefined:
  - The sub port remains but is ignored; add only.
  - The B-inversion and carry-preset logic is not synthesised.

## Test plan
- Reset: rst=1 for 2 cycles with start=1 and a=8'hFF → busy=0, done=0, sum=0, cout=0. Drop rst; no operation starts until start is seen with rst=0.
- Basic add (WIDTH=8): a=8'h3C, b=8'h5A, start for 1 cycle.
  - done pulses exactly 8 cycles after the accept edge, for 1 cycle.
  - sum=8'h96, cout=0.
  - Values are held for 20 idle cycles.
- Carry cases:
  - a=8'hFF, b=8'h01 → sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
  - a=0, b=0 → sum=0, cout=0.
- Handshake:
  - start=1 with a=8'h11 in the 3rd RUN cycle of the 3C+5A op → ignored; result still 8'h96.
  - start in the DONE cycle with a=8'h01, b=8'h02 → busy next edge; sum=8'h03 after 8 more cycles.
- Subtract:
  - With macro: a=8'h07, b=8'h05, sub=1 → sum=8'h02, cout=1.
  - With macro: a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0.
  - Without macro: a=8'h05, b=8'h07, sub=1 → sum=8'h0C, cout=0.
- Abort, plus WIDTH=1 and WIDTH=16 builds:
  - rst pulse during bit 4 → no done, outputs 0; the following op a=8'h80, b=8'h80 gives sum=8'h00, cout=1.
  - WIDTH=1: 1+1 gives sum=0, cout=1, done 1 cycle after accept.
  - WIDTH=16: 16'hFFFF+16'h0001 gives sum=16'h0000, cout=1, done 16 cycles after accept.
